brick_map_arbiter: RTL and testbench

Owns the brick-map RAM and shares its single port between the video renderer and the game logic. Renderer reads have absolute priority and fixed 1-cycle latency. The game logic issues atomic "hit" operations (test-and-decrement of a brick's hit points), and a level-init sequencer refills the whole map. The block also tracks remaining bricks for level-complete detection. It sits between the frame-rate game logic and the pixel pipeline.

---
 rtl/brick_map_arbiter_pkg.sv | 19 +
 rtl/brick_map_ram.sv | 29 ++
 rtl/brick_map_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_brick_map_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_map_arbiter_pkg.sv
// Shared brick-map geometry and FSM state encodings for the brick map arbiter.
package brick_map_arbiter_pkg;

    localparam int GRID_COLS  = 16;
    localparam int GRID_ROWS  = 8;
    localparam int NUM_BRICKS = GRID_COLS * GRID_ROWS;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 2;
    localparam int CNT_W      = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HIT_RD = 3'd1,
        ST_HIT_WR = 3'd2,
        ST_DONE   = 3'd3,
        ST_FILL   = 3'd4
    } state_e;

endpackage

// File: rtl/brick_map_ram.sv
// Single-port synchronous brick RAM, one-cycle read latency, contents not reset.
module brick_map_ram
    import brick_map_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [NUM_BRICKS];
    logic [DATA_W-1:0] rdata_q;

    // One access per cycle: either write the addressed brick or register its value.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/brick_map_arbiter.sv
// Brick map arbiter: shares the brick RAM port between renderer reads (top
// priority, fixed 1-cycle latency) and atomic hit / level-fill operations.
// Optional feature macro BRICK_COUNT_EN enables the bricks-left counter and
// the LEVEL_CLEAR pulse; without it both outputs are tied to zero.
module brick_map_arbiter
    import brick_map_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              log_req,
    input  logic [ADDR_W-1:0] log_addr,
    output logic              log_busy,
    output logic              log_done,
    output logic [DATA_W-1:0] log_prev,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] fill_data,
    output logic [CNT_W-1:0]  bricks_left,
    output logic              level_clear
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              vid_valid_q, vid_valid_d;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] cur_v;
    logic              addr_ok;

`ifdef BRICK_COUNT_EN
    logic [CNT_W-1:0]  left_q, left_d;
    logic              lc_q, lc_d;
`endif

    brick_map_ram u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Hit value: straight from the RAM in the cycle after the read, then from the hold register.
    assign cur_v   = rd_pend_q ? ram_rdata : hold_q;
    assign addr_ok = ({1'b0, addr_q} < CNT_W'(NUM_BRICKS));

    // Port arbitration and next-state logic; a renderer request always owns the port.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_pend_d   = 1'b0;
        hold_d      = cur_v;
        busy_d      = busy_q;
        done_d      = 1'b0;
        prev_d      = prev_q;
        vid_valid_d = vid_req;
        ram_en      = vid_req;
        ram_we      = 1'b0;
        ram_addr    = vid_addr;
        ram_wdata   = fill_data;
`ifdef BRICK_COUNT_EN
        left_d      = left_q;
        lc_d        = 1'b0;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (clear_start) begin
                    state_d = ST_FILL;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end else if (log_req) begin
                    state_d = ST_HIT_RD;
                    addr_d  = log_addr;
                    busy_d  = 1'b1;
                end
            end
            ST_HIT_RD: begin
                if (!addr_ok) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    prev_d  = '0;
                    busy_d  = 1'b0;
                end else if (!vid_req) begin
                    ram_en    = 1'b1;
                    ram_addr  = addr_q;
                    rd_pend_d = 1'b1;
                    state_d   = ST_HIT_WR;
                end
            end
            ST_HIT_WR: begin
                if ((cur_v == '0) || !vid_req) begin
                    if (cur_v != '0) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = addr_q;
                        ram_wdata = cur_v - DATA_W'(1);
                    end
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    prev_d  = cur_v;
                    busy_d  = 1'b0;
`ifdef BRICK_COUNT_EN
                    if ((cur_v == DATA_W'(1)) && (left_q != '0)) begin
                        left_d = left_q - CNT_W'(1);
                        lc_d   = (left_q == CNT_W'(1));
                    end
`endif
                end
            end
            ST_FILL: begin
                if (!vid_req) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = addr_q;
                    ram_wdata = fill_data;
                    if (addr_q == ADDR_W'(NUM_BRICKS - 1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
`ifdef BRICK_COUNT_EN
                        left_d  = (fill_data != '0) ? CNT_W'(NUM_BRICKS) : '0;
`endif
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rd_pend_q   <= 1'b0;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            prev_q      <= '0;
            vid_valid_q <= 1'b0;
`ifdef BRICK_COUNT_EN
            left_q      <= '0;
            lc_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_pend_q   <= rd_pend_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            prev_q      <= prev_d;
            vid_valid_q <= vid_valid_d;
`ifdef BRICK_COUNT_EN
            left_q      <= left_d;
            lc_q        <= lc_d;
`endif
        end
    end

    assign vid_valid = vid_valid_q;
    assign vid_data  = vid_valid_q ? ram_rdata : '0;
    assign log_busy  = busy_q;
    assign log_done  = done_q;
    assign log_prev  = prev_q;

`ifdef BRICK_COUNT_EN
    assign bricks_left = left_q;
    assign level_clear = lc_q;
`else
    assign bricks_left = '0;
    assign level_clear = 1'b0;
`endif

endmodule

// File: tb/tb_brick_map_arbiter.sv
// Directed bench for brick_map_arbiter: fill, hit, video contention,
// level-clear and reset-abort scenarios with hand-computed expectations.
module tb_brick_map_arbiter;
    import brick_map_arbiter_pkg::*;

`ifdef BRICK_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_data;
    logic              log_req;
    logic [ADDR_W-1:0] log_addr;
    logic              log_busy;
    logic              log_done;
    logic [DATA_W-1:0] log_prev;
    logic              clear_start;
    logic [DATA_W-1:0] fill_data;
    logic [CNT_W-1:0]  bricks_left;
    logic              level_clear;

    int total;
    int bad;
    int lc_seen;

    typedef struct {
        bit          is_hit;
        logic [6:0]  addr;
        int          exp_val;
        int          exp_left;
    } vec_t;

    vec_t vecs [11];

    brick_map_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_valid   (vid_valid),
        .vid_data    (vid_data),
        .log_req     (log_req),
        .log_addr    (log_addr),
        .log_busy    (log_busy),
        .log_done    (log_done),
        .log_prev    (log_prev),
        .clear_start (clear_start),
        .fill_data   (fill_data),
        .bricks_left (bricks_left),
        .level_clear (level_clear)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int expLeft(input int n);
        return CNT_EN ? n : 0;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Renderer read: request this cycle, data expected one cycle later.
    task automatic vidRead(input logic [ADDR_W-1:0] addr, input int expected, input string name);
        vid_req  = 1'b1;
        vid_addr = addr;
        @(posedge clk);
        #1;
        vid_req = 1'b0;
        checkOutput({name, "_valid"}, int'(vid_valid), 1);
        checkOutput({name, "_data"}, int'(vid_data), expected);
    endtask

    // Level fill: measures edges from CLEAR_START until busy falls, counting stray LOG_DONEs.
    task automatic fillMap(input logic [DATA_W-1:0] data, input bit with_log_req, input string name);
        int cnt;
        int dones;
        fill_data   = data;
        clear_start = 1'b1;
        log_req     = with_log_req;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        log_req     = 1'b0;
        cnt   = 1;
        dones = 0;
        checkOutput({name, "_busy_start"}, int'(log_busy), 1);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            cnt++;
            #1;
            if (log_done) dones++;
            if (!log_busy) break;
        end
        checkOutput({name, "_latency"}, cnt, NUM_BRICKS + 1);
        checkOutput({name, "_stray_done"}, dones, 0);
        checkOutput({name, "_left"}, int'(bricks_left), expLeft((data != 0) ? NUM_BRICKS : 0));
    endtask

    // Hit operation: request, wait bounded for LOG_DONE, check result and one-cycle pulses.
    task automatic hitOp(input logic [ADDR_W-1:0] addr, input int exp_prev, input int exp_left,
                         input int exp_lc, input int exp_lat, input string name);
        int lat;
        log_req  = 1'b1;
        log_addr = addr;
        @(posedge clk);
        lat = 1;
        #1;
        log_req = 1'b0;
        checkOutput({name, "_busy"}, int'(log_busy), 1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (level_clear) lc_seen++;
            if (log_done) break;
        end
        checkOutput({name, "_latency"}, lat, exp_lat);
        checkOutput({name, "_prev"}, int'(log_prev), exp_prev);
        checkOutput({name, "_left"}, int'(bricks_left), exp_left);
        checkOutput({name, "_lc"}, int'(level_clear), exp_lc);
        @(posedge clk);
        #1;
        if (level_clear) lc_seen++;
        checkOutput({name, "_done_width"}, int'(log_done), 0);
        checkOutput({name, "_busy_after"}, int'(log_busy), 0);
    endtask

    // Table of renderer reads and hits applied after a FILL_DATA=2 fill.
    task automatic applyStimulus();
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_hit) begin
                hitOp(vecs[i].addr, vecs[i].exp_val, vecs[i].exp_left, 0, 3, $sformatf("tbl%0d_hit", i));
            end else begin
                vidRead(vecs[i].addr, vecs[i].exp_val, $sformatf("tbl%0d_rd", i));
            end
        end
    endtask

    initial begin
        int lat;
        logic [ADDR_W-1:0] c_addr [4];
        int c_exp [4];

        total = 0;
        bad = 0;
        lc_seen = 0;
        reset_n = 1'b0;
        vid_req = 1'b0;
        vid_addr = '0;
        log_req = 1'b0;
        log_addr = '0;
        clear_start = 1'b0;
        fill_data = '0;

        vecs[0]  = '{1'b0, 7'd5,   2, 0};
        vecs[1]  = '{1'b1, 7'd5,   2, expLeft(128)};
        vecs[2]  = '{1'b0, 7'd5,   1, 0};
        vecs[3]  = '{1'b1, 7'd5,   1, expLeft(127)};
        vecs[4]  = '{1'b0, 7'd5,   0, 0};
        vecs[5]  = '{1'b1, 7'd5,   0, expLeft(127)};
        vecs[6]  = '{1'b0, 7'd4,   2, 0};
        vecs[7]  = '{1'b1, 7'd127, 2, expLeft(127)};
        vecs[8]  = '{1'b0, 7'd127, 1, 0};
        vecs[9]  = '{1'b1, 7'd0,   2, expLeft(127)};
        vecs[10] = '{1'b0, 7'd0,   1, 0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_vid_valid", int'(vid_valid), 0);
        checkOutput("rst_vid_data", int'(vid_data), 0);
        checkOutput("rst_busy", int'(log_busy), 0);
        checkOutput("rst_done", int'(log_done), 0);
        checkOutput("rst_prev", int'(log_prev), 0);
        checkOutput("rst_left", int'(bricks_left), 0);
        checkOutput("rst_lc", int'(level_clear), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 2 and read every brick back.
        fillMap(2'd2, 1'b0, "fill2");
        for (int a = 0; a < NUM_BRICKS; a++) begin
            vidRead(ADDR_W'(a), 2, $sformatf("rd_all_%0d", a));
        end

        applyStimulus();

        // Renderer holds the port 4 cycles while a hit on brick 9 waits in HIT_RD.
        c_addr[0] = 7'd5;   c_exp[0] = 0;
        c_addr[1] = 7'd127; c_exp[1] = 1;
        c_addr[2] = 7'd0;   c_exp[2] = 1;
        c_addr[3] = 7'd9;   c_exp[3] = 2;
        log_req  = 1'b1;
        log_addr = 7'd9;
        @(posedge clk);
        lat = 1;
        #1;
        log_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vid_req  = 1'b1;
            vid_addr = c_addr[i];
            @(posedge clk);
            lat++;
            #1;
            checkOutput($sformatf("cont_vid_valid%0d", i), int'(vid_valid), 1);
            checkOutput($sformatf("cont_vid_data%0d", i), int'(vid_data), c_exp[i]);
            checkOutput($sformatf("cont_no_done%0d", i), int'(log_done), 0);
        end
        vid_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (log_done) break;
        end
        checkOutput("cont_latency", lat, 7);
        checkOutput("cont_prev", int'(log_prev), 2);
        @(posedge clk);
        #1;
        vidRead(7'd9, 1, "cont_reread");

        // Fill with 1, hit every brick: exactly one LEVEL_CLEAR, on the last hit.
        fillMap(2'd1, 1'b0, "fill1");
        lc_seen = 0;
        for (int a = 0; a < NUM_BRICKS; a++) begin
            hitOp(ADDR_W'(a), 1, expLeft(NUM_BRICKS - 1 - a), (CNT_EN && a == NUM_BRICKS - 1) ? 1 : 0, 3,
                  $sformatf("clr_hit%0d", a));
        end
        checkOutput("lc_pulse_count", lc_seen, CNT_EN ? 1 : 0);
        hitOp(7'd0, 0, 0, 0, 3, "extra_hit");
        vidRead(7'd64, 0, "cleared_rd");

        // CLEAR_START beats a simultaneous LOG_REQ; the hit is dropped.
        log_addr = 7'd10;
        fillMap(2'd3, 1'b1, "fill3_race");
        hitOp(7'd127, 3, expLeft(128), 0, 3, "hit_last_addr");
        hitOp(7'd10, 3, expLeft(128), 0, 3, "hit_dropped_addr");

        // Reset during a fill clears every output asynchronously.
        fill_data   = 2'd2;
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        vid_req  = 1'b1;
        vid_addr = 7'd3;
        @(posedge clk);
        #1;
        vid_req = 1'b0;
        checkOutput("midfill_busy", int'(log_busy), 1);
        checkOutput("midfill_vid_valid", int'(vid_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_vid_valid", int'(vid_valid), 0);
        checkOutput("arst_vid_data", int'(vid_data), 0);
        checkOutput("arst_busy", int'(log_busy), 0);
        checkOutput("arst_done", int'(log_done), 0);
        checkOutput("arst_prev", int'(log_prev), 0);
        checkOutput("arst_left", int'(bricks_left), 0);
        checkOutput("arst_lc", int'(level_clear), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_rst_busy", int'(log_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
